// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment display path.
//   GLYPH_*      5-bit glyph codes produced by the game-state counters
//                (values 0..9 are plain decimal digits)
//   SEG_BLANK    all cathodes off (active-low)
//   AN_OFF       all anodes off (active-low)
//   NUM_DIGITS   digits on the Basys 3 display
//   seg_t/an_t   convenience types for cathode and anode buses
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [4:0] GLYPH_A     = 5'd10;
    localparam logic [4:0] GLYPH_B     = 5'd11;
    localparam logic [4:0] GLYPH_C     = 5'd12;
    localparam logic [4:0] GLYPH_D     = 5'd13;
    localparam logic [4:0] GLYPH_E     = 5'd14;
    localparam logic [4:0] GLYPH_F     = 5'd15;
    localparam logic [4:0] GLYPH_H     = 5'd16;
    localparam logic [4:0] GLYPH_L     = 5'd17;
    localparam logic [4:0] GLYPH_P     = 5'd18;
    localparam logic [4:0] GLYPH_BLANK = 5'd31;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam an_t  AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg_glyph_decode
// Combinational glyph-code to cathode decoder.
//   code  in  5  glyph code: 0..9 digits, 10..18 letters A b C d E F H L P,
//                anything else renders blank
//   seg   out 7  cathodes {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            GLYPH_A: seg = 7'b0001000;
            GLYPH_B: seg = 7'b0000011;
            GLYPH_C: seg = 7'b1000110;
            GLYPH_D: seg = 7'b0100001;
            GLYPH_E: seg = 7'b0000110;
            GLYPH_F: seg = 7'b0001110;
            GLYPH_H: seg = 7'b0001001;
            GLYPH_L: seg = 7'b1000111;
            GLYPH_P: seg = 7'b0001100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
// Time-multiplexes four glyph codes onto a 4-digit common-anode display with
// per-digit decimal points and a per-digit blink mask.
//   clk         in   1  system clock
//   reset       in   1  asynchronous active-high reset
//   en          in   1  0 blanks all anodes; scan counters keep running
//   code0..3    in   5  glyph codes, code0 = rightmost digit (an[0])
//   dp_in       in   4  decimal point per digit, 1 = lit
//   blink_mask  in   4  1 = digit takes part in blinking
//   an          out  4  anodes, active-low, one-cold while lit
//   seg         out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point cathode, active-low
//   frame_tick  out  1  one-clock pulse when the digit-3 slot begins
// Parameters:
//   REFRESH_DIV clk cycles per digit slot
//   BLINK_DIV   slot ticks per blink half-period
// -----------------------------------------------------------------------------
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [4:0] code0,
    input  logic [4:0] code1,
    input  logic [4:0] code2,
    input  logic [4:0] code3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blink_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    // A divider of 1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    an_t              an_q, an_d;
    seg_t             seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------
    // Per-digit selection
    // ------------------------------------------------------------------
    logic [4:0] code_in [NUM_DIGITS];
    an_t        onecold;
    logic [4:0] cur_code;
    seg_t       cur_seg;
    logic       slot_tick;
    logic       blink_off;

    assign code_in[0] = code0;
    assign code_in[1] = code1;
    assign code_in[2] = code2;
    assign code_in[3] = code3;

    // Anode pattern for the digit about to be shown: only idx_q pulled low.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_onecold
            assign onecold[gi] = (idx_q != 2'(gi));
        end
    endgenerate

    assign cur_code  = code_in[idx_q];
    assign slot_tick = (refresh_cnt_q == REF_LAST);
    // Phase in effect before this tick's blink-counter update decides darkness.
    assign blink_off = blink_phase_q & blink_mask[idx_q];

    seg_glyph_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        refresh_cnt_d = slot_tick ? '0 : refresh_cnt_q + REF_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;
        frame_tick_d  = 1'b0;

        if (slot_tick) begin
            // Inputs are sampled only here; mid-slot changes wait for the
            // digit's next slot.
            seg_d        = cur_seg;
            dp_d         = ~dp_in[idx_q];
            an_d         = blink_off ? AN_OFF : onecold;
            frame_tick_d = (idx_q == 2'd3);
            idx_d        = idx_q + 2'd1;

            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        // Disable only darkens the anodes; scanning continues so the
        // sequence stays in step when the display is re-enabled.
        if (!en) begin
            an_d = AN_OFF;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            idx_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
